i2c_imu_target: RTL

- Synthesizable I2C target (slave) that emulates the IMU's register interface: the responder end of the bus our IMU driver initiates on.
- Used in simulation and on-board loopback to exercise the driver against real address, pointer-write, data-write and repeated-start read traffic, replacing blind every-9th-edge ACKing.
- Open-drain SDA only. SCL is input-only; no clock stretching.

---
 rtl/i2c_imu_target.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_imu_target.sv
// I2C target emulating the IMU register map: 7-bit address match, pointer write,
// auto-incrementing data write/read, repeated start, open-drain SDA, no stretching.
module i2c_imu_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h28,
  parameter logic [7:0] CHIP_ID     = 8'hA0,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       host_wr_en,
  input  logic [7:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  output logic       bus_wr_valid,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic       busy
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic rise_q, fall_q, start_q, stop_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Idle bus is high, so synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q[0] <= scl_in;
      sda_sync_q[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      rise_q     <= scl_s & ~scl_prev_q;
      fall_q     <= ~scl_s & scl_prev_q;
      start_q    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_q     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end
  end

  state_t        st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          ack_q, ack_d, rw_q, rw_d, oe_q, oe_d, busy_q, busy_d;
  logic          ptr_wr_q, ptr_wr_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          wr_valid_q;
  logic [7:0]    wr_addr_q, wr_data_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic          sda_b, bus_wr_c;
  logic [7:0]    byte_c, rd_byte;
  logic [IW-1:0] host_idx;

  // sda_prev_q holds the synchronized SDA level from the cycle the edge was seen.
  assign sda_b    = sda_prev_q;
  assign byte_c   = {sh_q[6:0], sda_b};
  assign rd_byte  = (ptr_q == '0) ? CHIP_ID : regs_q[ptr_q];
  assign host_idx = host_wr_addr[IW-1:0];

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ack_d    = ack_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    ptr_wr_d = ptr_wr_q;
    bus_wr_c = 1'b0;
    if (stop_q) begin
      st_d     = IDLE;
      oe_d     = 1'b0;
      ack_d    = 1'b0;
      busy_d   = 1'b0;
      ptr_wr_d = 1'b0;
    end else if (start_q) begin
      st_d  = ADDR;
      cnt_d = '0;
      oe_d  = 1'b0;
      ack_d = 1'b0;
      if (st_q == IDLE) ptr_wr_d = 1'b0;
    end else begin
      unique case (st_q)
        ADDR, PTR, WDATA: if (rise_q) begin
          sh_d  = byte_c;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (st_q == ADDR) begin
              if (byte_c[7:1] == DEVICE_ADDR) begin
                st_d   = ADDR_ACK;
                rw_d   = byte_c[0];
                busy_d = 1'b1;
              end else begin
                st_d   = IDLE;
                busy_d = 1'b0;
              end
            end else if (st_q == PTR) begin
              ptr_d    = byte_c[IW-1:0];
              ptr_wr_d = 1'b1;
              st_d     = PTR_ACK;
            end else begin
              bus_wr_c = (ptr_q != '0);
              st_d     = WDATA_ACK;
            end
          end
        end
        // First fall pulls SDA low for the ACK slot, second fall releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (fall_q) begin
          if (!ack_q) begin
            ack_d = 1'b1;
            oe_d  = 1'b1;
          end else begin
            ack_d = 1'b0;
            oe_d  = 1'b0;
            cnt_d = '0;
            st_d  = WDATA;
            if (st_q == ADDR_ACK) begin
              if (rw_q) begin
                st_d  = RDATA;
                oe_d  = ~rd_byte[7];
                sh_d  = {rd_byte[6:0], 1'b0};
                cnt_d = 4'd1;
              end else if (!ptr_wr_q) begin
                st_d = PTR;
              end
            end else if (st_q == WDATA_ACK) begin
              ptr_d = ptr_q + IW'(1);
            end
          end
        end
        RDATA: if (fall_q) begin
          if (cnt_q == 4'd0) begin
            oe_d  = ~rd_byte[7];
            sh_d  = {rd_byte[6:0], 1'b0};
            cnt_d = 4'd1;
          end else if (cnt_q == 4'd8) begin
            oe_d = 1'b0;
            st_d = RACK;
          end else begin
            oe_d  = ~sh_q[7];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
          end
        end
        RACK: if (rise_q && !sda_b) begin
          ptr_d = ptr_q + IW'(1);
          cnt_d = '0;
          st_d  = RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      ack_q      <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      ptr_wr_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      ptr_wr_q   <= ptr_wr_d;
      wr_valid_q <= bus_wr_c;
      if (bus_wr_c) begin
        wr_addr_q <= 8'(ptr_q);
        wr_data_q <= byte_c;
      end
    end
  end

  // Bus write is assigned last so it wins over a same-cycle host write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (host_wr_en && host_idx != '0) regs_q[host_idx] <= host_wr_data;
      if (bus_wr_c) regs_q[ptr_q] <= byte_c;
    end
  end

  assign sda_oe       = oe_q;
  assign busy         = busy_q;
  assign bus_wr_valid = wr_valid_q;
  assign bus_wr_addr  = wr_addr_q;
  assign bus_wr_data  = wr_data_q;
endmodule
